// File: rtl/pid_ctrl_gen.sv
`default_nettype none
// ============================================================================
// Module   : pid_ctrl_gen
// Brief    : Decimated PI(D) drive controller with clamped integrator,
//            anti-windup and a two-stage saturating output pipeline.
//            Optional derivative term enabled by macro PID_DTERM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pid_ctrl_gen #(
   parameter int ERR_W    = 13,
   parameter int OUT_W    = 12,
   parameter int INT_W    = 18,
   parameter int DECIM_W  = 20,
   parameter int D_DEPTH  = 3,
   parameter int D_SAT_W  = 9,
   parameter int KD_SHIFT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [ERR_W-1:0] error,
   input  logic             clr,
   input  logic             aw_en,
   output logic [OUT_W-1:0] drv_mag,
   output logic             drv_vld,
   output logic             sat_hi,
   output logic             sat_lo
);

   localparam int c_d_w   = D_SAT_W + KD_SHIFT;
   localparam int c_pa_w  = (ERR_W > OUT_W + 1) ? ERR_W : OUT_W + 1;
   // Sum width covers the worst case of every term so PID can never wrap.
   localparam int c_pid_w = ((c_pa_w > c_d_w) ? c_pa_w : c_d_w) + 2;
   localparam logic [INT_W-1:0] c_int_max = {1'b0, {(INT_W-1){1'b1}}};

   generate
      if (INT_W < OUT_W + 2 || INT_W <= ERR_W || D_DEPTH < 1 || D_DEPTH > 8 ||
          D_SAT_W > ERR_W + 1 || D_SAT_W < 2) begin : g_param_chk
         $error("pid_ctrl_gen: illegal parameter combination");
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Update-rate decimator
   // ------------------------------------------------------------------------
   logic [DECIM_W-1:0] r_decim;
   logic               w_tick;

   assign w_tick = &r_decim;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_decim <= '0;
      end else begin
         r_decim <= r_decim + 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Integrator with clamping and anti-windup
   // ------------------------------------------------------------------------
   logic [INT_W-1:0] r_integ;
   logic [INT_W-1:0] w_err_ext;
   logic [INT_W-1:0] w_sum;
   logic [INT_W-1:0] w_integ_nxt;
   logic             w_err_pos;
   logic             w_err_neg;
   logic             w_hold;

   assign w_err_ext = {{(INT_W-ERR_W){error[ERR_W-1]}}, error};
   assign w_sum     = r_integ + w_err_ext;
   assign w_err_neg = error[ERR_W-1];
   assign w_err_pos = !error[ERR_W-1] && (|error);
   assign w_hold    = aw_en && ((sat_hi && w_err_pos) || (sat_lo && w_err_neg));

   // The integrator is never negative, so a set sign bit is either an
   // underflow (clamp to 0) or, with the top magnitude bit set, an overflow.
   always_comb begin
      w_integ_nxt = w_sum;
      if (w_sum[INT_W-1]) begin
         w_integ_nxt = r_integ[INT_W-2] ? c_int_max : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_integ <= '0;
      end else if (clr) begin
         r_integ <= '0;
      end else if (w_tick && !w_hold) begin
         r_integ <= w_integ_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Derivative term
   // ------------------------------------------------------------------------
   logic [c_d_w-1:0] w_d_term;

`ifdef PID_DTERM_EN
   localparam logic signed [ERR_W:0] c_dmax = (ERR_W+1)'(2**(D_SAT_W-1) - 1);
   localparam logic signed [ERR_W:0] c_dmin = (ERR_W+1)'(-(2**(D_SAT_W-1)));

   logic [ERR_W-1:0]   r_hist [D_DEPTH];
   logic [ERR_W:0]     w_ddiff;
   logic [D_SAT_W-1:0] w_dsat;
   logic [c_d_w-1:0]   w_dsat_x;
   logic [c_d_w-1:0]   w_d;
   logic [c_d_w-1:0]   r_d;

   assign w_ddiff = {error[ERR_W-1], error} -
                    {r_hist[D_DEPTH-1][ERR_W-1], r_hist[D_DEPTH-1]};

   always_comb begin
      w_dsat = w_ddiff[D_SAT_W-1:0];
      if ($signed(w_ddiff) > c_dmax) begin
         w_dsat = c_dmax[D_SAT_W-1:0];
      end else if ($signed(w_ddiff) < c_dmin) begin
         w_dsat = c_dmin[D_SAT_W-1:0];
      end
   end

   assign w_dsat_x = c_d_w'($signed(w_dsat));
   assign w_d      = w_dsat_x << KD_SHIFT;

   // Entry 0 is the newest sample; the last entry feeds the difference.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < D_DEPTH; k++) r_hist[k] <= '0;
         r_d <= '0;
      end else begin
         r_d <= w_d;
         if (clr) begin
            for (int k = 0; k < D_DEPTH; k++) r_hist[k] <= '0;
         end else if (w_tick) begin
            r_hist[0] <= error;
            for (int k = 1; k < D_DEPTH; k++) r_hist[k] <= r_hist[k-1];
         end
      end
   end

   assign w_d_term = r_d;
`else
   assign w_d_term = '0;
`endif

   // ------------------------------------------------------------------------
   // Stage 1: register P, I (and D); stage 2: saturate the sum
   // ------------------------------------------------------------------------
   logic [ERR_W-1:0]   r_p;
   logic [OUT_W-1:0]   r_i;
   logic               r_vld1;
   logic [c_pid_w-1:0] w_pid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_p    <= '0;
         r_i    <= '0;
         r_vld1 <= 1'b0;
      end else begin
         r_p    <= error;
         r_i    <= r_integ[INT_W-2 -: OUT_W];
         r_vld1 <= w_tick;
      end
   end

   assign w_pid = {{(c_pid_w-ERR_W){r_p[ERR_W-1]}}, r_p}
                + {{(c_pid_w-OUT_W){1'b0}}, r_i}
                + {{(c_pid_w-c_d_w){w_d_term[c_d_w-1]}}, w_d_term};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drv_mag <= '0;
         drv_vld <= 1'b0;
         sat_hi  <= 1'b0;
         sat_lo  <= 1'b0;
      end else begin
         drv_vld <= r_vld1;
         if (w_pid[c_pid_w-1]) begin
            drv_mag <= '0;
            sat_lo  <= 1'b1;
            sat_hi  <= 1'b0;
         end else if (|w_pid[c_pid_w-2:OUT_W]) begin
            drv_mag <= '1;
            sat_hi  <= 1'b1;
            sat_lo  <= 1'b0;
         end else begin
            drv_mag <= w_pid[OUT_W-1:0];
            sat_hi  <= 1'b0;
            sat_lo  <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire
